// File: rtl/fb_arbiter_pkg.sv
// Frame-buffer geometry shared by the VGA timing, Sobel writer and arbiter blocks.
// Latency: n/a (constants and a helper only).
// Backpressure: n/a.
package fb_arbiter_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_W     = 16;
  localparam int FB_WORDS = H_ACTIVE * V_ACTIVE / FB_W;
  localparam int FB_AW    = 15;

  // Words needed to hold one frame of h x v one-bit pixels packed w per word.
  function automatic int fb_words(input int h, input int v, input int w);
    return h * v / w;
  endfunction

endpackage

// File: rtl/fb_pixel_shifter.sv
// Two-slot ping-pong prefetch buffer shifted out LSB first, one bit per pixel.
// Latency: pix_data is combinational from the head slot; a read fills the tail slot one cycle after issue.
// Backpressure: none; pix_req on an empty head yields 0 and the pixel is lost.
module fb_pixel_shifter
  import fb_arbiter_pkg::*;
#(
  parameter int W = FB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic         pix_req,
  input  logic         rd_issue,
  input  logic [W-1:0] rd_data,
  output logic         pix_data,
  output logic         head_vld,
  output logic [1:0]   slot_free
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  logic [W-1:0]  slot_q [2];
  logic [W-1:0]  slot_d [2];
  logic [1:0]    vld_q, vld_d;
  logic          hd_q, hd_d;
  logic          tl_q, tl_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          gen_q, gen_d;
  logic          fl_q, fl_d;
  logic          fl_gen_q, fl_gen_d;

  logic pop;
  logic head_freed;
  logic ret_ok;

  // Head/occupancy view used by the arbiter, plus the consume and fill events for this cycle.
  always_comb begin
    head_vld   = vld_q[hd_q];
    pix_data   = head_vld ? slot_q[hd_q][bit_q] : 1'b0;
    slot_free  = 2'd2 - {1'b0, vld_q[0]} - {1'b0, vld_q[1]} - {1'b0, fl_q};
    pop        = pix_req && head_vld && !frame_start;
    head_freed = pop && (bit_q == LAST_BIT);
    // A return tagged with an older generation belongs to the previous frame.
    ret_ok     = fl_q && (fl_gen_q == gen_q) && !frame_start;
  end

  // Next-state: frame_start wipes the buffer; otherwise a fill and a free may land together.
  always_comb begin
    slot_d   = slot_q;
    vld_d    = vld_q;
    hd_d     = hd_q;
    tl_d     = tl_q;
    bit_d    = bit_q;
    gen_d    = gen_q;
    fl_d     = fl_q;
    fl_gen_d = fl_gen_q;
    if (frame_start) begin
      vld_d = 2'b00;
      hd_d  = 1'b0;
      tl_d  = 1'b0;
      bit_d = '0;
      gen_d = ~gen_q;
      fl_d  = 1'b0;
    end else begin
      fl_d     = rd_issue;
      fl_gen_d = gen_q;
      // The tail is always the empty slot while a read is outstanding, so it never collides with the head free.
      if (ret_ok) begin
        slot_d[tl_q] = rd_data;
        vld_d[tl_q]  = 1'b1;
        tl_d         = ~tl_q;
      end
      if (head_freed) begin
        vld_d[hd_q] = 1'b0;
        hd_d        = ~hd_q;
        bit_d       = '0;
      end else if (pop) begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      vld_q     <= 2'b00;
      hd_q      <= 1'b0;
      tl_q      <= 1'b0;
      bit_q     <= '0;
      gen_q     <= 1'b0;
      fl_q      <= 1'b0;
      fl_gen_q  <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      vld_q     <= vld_d;
      hd_q      <= hd_d;
      tl_q      <= tl_d;
      bit_q     <= bit_d;
      gen_q     <= gen_d;
      fl_q      <= fl_d;
      fl_gen_q  <= fl_gen_d;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Shares the single-port frame-buffer RAM between the display prefetch reader and the Sobel writer.
// Latency: RAM access issued combinationally in the request cycle; read data lands in the buffer one cycle later.
// Backpressure: wr_ready drops only in cycles the display claims for a prefetch read.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int W  = FB_W,
  parameter int H  = H_ACTIVE,
  parameter int V  = V_ACTIVE,
  parameter int AW = FB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          pix_req,
  output logic          pix_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  output logic          underrun,
  output logic          addr_err
);

  localparam int WORDS = fb_words(H, V, W);
  // One extra bit so the idle value WORDS is representable even when 2^AW == WORDS.
  localparam logic [AW:0] WORDS_V = (AW + 1)'(WORDS);

  logic [AW:0] rd_addr_q, rd_addr_d;
  logic        underrun_q, underrun_d;
  logic        addr_err_q, addr_err_d;

  logic        need_rd;
  logic        wr_fire;
  logic        wr_in_range;
  logic        head_vld;
  logic [1:0]  slot_free;

  fb_pixel_shifter #(
    .W (W)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .rd_issue    (need_rd),
    .rd_data     (mem_rdata),
    .pix_data    (pix_data),
    .head_vld    (head_vld),
    .slot_free   (slot_free)
  );

  // Arbitration: the display read wins whenever a slot is free and the frame is not exhausted.
  always_comb begin
    need_rd     = !rst && (slot_free != 2'd0) && (rd_addr_q < WORDS_V) && !frame_start;
    wr_ready    = !rst && !need_rd;
    wr_fire     = wr_valid && wr_ready;
    wr_in_range = ({1'b0, wr_addr} < WORDS_V);
    mem_en      = need_rd || (wr_fire && wr_in_range);
    mem_we      = !need_rd && wr_fire && wr_in_range;
    mem_addr    = need_rd ? rd_addr_q[AW-1:0] : wr_addr;
    mem_wdata   = mem_we ? wr_data : '0;
  end

  // Next read address and the sticky error flags.
  always_comb begin
    rd_addr_d  = rd_addr_q;
    underrun_d = underrun_q;
    addr_err_d = addr_err_q;
    if (frame_start) begin
      rd_addr_d = '0;
    end else if (need_rd) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
    if (pix_req && !head_vld && !frame_start) begin
      underrun_d = 1'b1;
    end
    if (wr_fire && !wr_in_range) begin
      addr_err_d = 1'b1;
    end
  end

  // Top-level state registers; the reader starts idle until the first frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q  <= WORDS_V;
      underrun_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      underrun_q <= underrun_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign underrun = underrun_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios then randomized traffic against a queue model.
// Latency: checks at the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: writer offers are random; the model decides when the arbiter should accept.
module tb_fb_arbiter;

  localparam int W     = 16;
  localparam int AW    = 15;
  localparam int WORDS = 19200;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_req;
  logic          pix_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          underrun;
  logic          addr_err;

  always #5 clk = ~clk;

  fb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .underrun    (underrun),
    .addr_err    (addr_err)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM seen by the DUT, and the model's own copy of what the RAM should hold.
  logic [W-1:0] ram     [WORDS];
  logic [W-1:0] mdl_mem [WORDS];

  // Reference model: prefetched words as a queue, one outstanding read, bit position in the head word.
  logic [W-1:0] m_buf [$];
  int           m_rd_ptr;
  bit           m_infl;
  logic [W-1:0] m_infl_dat;
  int           m_bit;
  bit           m_under;
  bit           m_aerr;

  // RAM action captured this cycle and applied at the start of the next.
  bit            p_rd, p_wr;
  logic [AW-1:0] p_addr;
  logic [W-1:0]  p_dat;

  // DUT outputs sampled at the last falling edge.
  logic          o_en, o_we, o_rdy, o_pix, o_und, o_aerr;
  logic [AW-1:0] o_addr;
  logic [W-1:0]  o_wdat;

  task automatic model_reset();
    m_buf.delete();
    m_rd_ptr = WORDS;
    m_infl   = 1'b0;
    m_bit    = 0;
    m_under  = 1'b0;
    m_aerr   = 1'b0;
    p_rd     = 1'b0;
    p_wr     = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    frame_start = 1'b0;
    pix_req     = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    mem_rdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, check against the model at the falling edge, then advance the model.
  task automatic step(input bit fs, input bit pr, input bit wv, input int wa, input logic [W-1:0] wd);
    bit need, fire, okw, e_pix;
    int e_addr;
    if (p_wr) ram[p_addr] = p_dat;
    mem_rdata   = p_rd ? ram[p_addr] : W'($urandom);
    frame_start = fs;
    pix_req     = pr;
    wr_valid    = wv;
    wr_addr     = AW'(wa);
    wr_data     = wd;
    #4;
    need   = !fs && ((m_buf.size() + int'(m_infl)) < 2) && (m_rd_ptr < WORDS);
    fire   = wv && !need;
    okw    = fire && (wa < WORDS);
    e_pix  = (m_buf.size() > 0) ? m_buf[0][m_bit] : 1'b0;
    e_addr = need ? m_rd_ptr : wa;
    o_en = mem_en; o_we = mem_we; o_rdy = wr_ready; o_pix = pix_data;
    o_und = underrun; o_aerr = addr_err; o_addr = mem_addr; o_wdat = mem_wdata;
    check("wr_ready", 32'(o_rdy), 32'(!need));
    check("mem_en", 32'(o_en), 32'(need || okw));
    if (need || okw) begin
      check("mem_we", 32'(o_we), 32'(okw));
      check("mem_addr", 32'(o_addr), 32'(e_addr));
    end
    if (okw) check("mem_wdata", 32'(o_wdat), 32'(wd));
    check("pix_data", 32'(o_pix), 32'(e_pix));
    check("underrun", 32'(o_und), 32'(m_under));
    check("addr_err", 32'(o_aerr), 32'(m_aerr));
    p_rd   = mem_en && !mem_we && (int'(mem_addr) < WORDS);
    p_wr   = mem_en && mem_we && (int'(mem_addr) < WORDS);
    p_addr = mem_addr;
    p_dat  = mem_wdata;
    if (fs) begin
      m_buf.delete();
      m_bit    = 0;
      m_infl   = 1'b0;
      m_rd_ptr = 0;
    end else begin
      if (pr) begin
        if (m_buf.size() > 0) begin
          m_bit++;
          if (m_bit == W) begin
            void'(m_buf.pop_front());
            m_bit = 0;
          end
        end else begin
          m_under = 1'b1;
        end
      end
      if (m_infl) m_buf.push_back(m_infl_dat);
      m_infl = need;
      if (need) begin
        m_infl_dat = mdl_mem[m_rd_ptr];
        m_rd_ptr++;
      end
    end
    if (okw) mdl_mem[wa] = wd;
    if (fire && !okw) m_aerr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] w0, w1;
  bit           found;
  bit           r_fs, r_pr, r_wv;
  int           r_wa;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = W'($urandom);
      mdl_mem[i] = ram[i];
    end
    w0 = 16'hA5C3;
    w1 = 16'h0F0F;
    ram[0] = w0;     mdl_mem[0] = w0;
    ram[1] = w1;     mdl_mem[1] = w1;
    ram[7] = 16'h0;  mdl_mem[7] = 16'h0;

    do_reset();
    step(0, 0, 0, 0, '0);
    check("rst_mem_en", 32'(o_en), 32'd0);
    check("rst_pix", 32'(o_pix), 32'd0);
    check("rst_underrun", 32'(o_und), 32'd0);
    check("rst_addr_err", 32'(o_aerr), 32'd0);
    check("rst_wr_ready", 32'(o_rdy), 32'd1);

    // First write after reset goes straight through.
    step(0, 0, 1, 5, 16'h1234);
    check("w5_rdy", 32'(o_rdy), 32'd1);
    check("w5_we", 32'(o_we), 32'd1);
    check("w5_addr", 32'(o_addr), 32'd5);

    // frame_start with the writer still offering.
    step(1, 0, 1, 6, 16'h5678);
    check("fs_rdy", 32'(o_rdy), 32'd1);
    step(0, 0, 1, 6, 16'h5678);
    check("rd0_rdy", 32'(o_rdy), 32'd0);
    check("rd0_addr", 32'(o_addr), 32'd0);
    check("rd0_we", 32'(o_we), 32'd0);
    step(0, 0, 1, 6, 16'h5678);
    check("rd1_rdy", 32'(o_rdy), 32'd0);
    check("rd1_addr", 32'(o_addr), 32'd1);
    step(0, 0, 1, 6, 16'h5678);
    check("w6_rdy", 32'(o_rdy), 32'd1);
    check("w6_we", 32'(o_we), 32'd1);

    // 32 pixels: word 0 then word 1, refill of addr 2 right after word 0 drains.
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0, 0, '0);
      check("pix_seq", 32'(o_pix), 32'((i < 16) ? w0[i] : w1[i-16]));
      if (i == 16) begin
        check("rd2_en", 32'(o_en), 32'd1);
        check("rd2_we", 32'(o_we), 32'd0);
        check("rd2_addr", 32'(o_addr), 32'd2);
      end
    end
    check("no_underrun", 32'(o_und), 32'd0);

    // Pixel requested before anything has been prefetched.
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    check("ur_pix", 32'(o_pix), 32'd0);
    step(0, 0, 0, 0, '0);
    check("ur_set", 32'(o_und), 32'd1);
    repeat (5) step(0, 0, 0, 0, '0);
    check("ur_sticky", 32'(o_und), 32'd1);

    // frame_start lands while the read of addr 7 is returning.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(0, 1, 0, 0, '0);
      if (o_en && !o_we && o_addr == AW'(7)) found = 1'b1;
    end
    check("rd7_seen", 32'(found), 32'd1);
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    check("stale_rd0", 32'(o_addr), 32'd0);
    step(0, 0, 0, 0, '0);
    check("stale_rd1", 32'(o_addr), 32'd1);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, '0);
      check("stale_pix", 32'(o_pix), 32'(w0[i]));
    end

    // Out-of-range write is accepted but never reaches the RAM.
    step(0, 0, 1, WORDS, 16'hDEAD);
    check("bad_rdy", 32'(o_rdy), 32'd1);
    check("bad_en", 32'(o_en), 32'd0);
    step(0, 0, 0, 0, '0);
    check("bad_aerr", 32'(o_aerr), 32'd1);

    // Randomized traffic with occasional frame starts, bad addresses and mid-frame resets.
    for (int c = 0; c < 6000; c++) begin
      if (c % 1500 == 1499) do_reset();
      r_fs = ($urandom_range(0, 299) == 0) || (c % 1500 == 0);
      r_pr = $urandom_range(0, 1) == 1;
      r_wv = $urandom_range(0, 1) == 1;
      r_wa = ($urandom_range(0, 49) == 0) ? WORDS + int'($urandom_range(0, 32767 - WORDS))
                                          : int'($urandom_range(0, WORDS - 1));
      step(r_fs, r_pr, r_wv, r_wa, W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
